// File: rtl/idli_xu_m.sv
// idli_xu_m: parametrised bit-serial execution unit.
// Consumes LSB-first operand slices, emits result slices with a register-file
// write enable, and latches carry/compare flags at the end of each instruction.
// Optional feature macro: IDLI_XU_SHIFT_EN enables SHL (op 7); otherwise op 7
// is accepted but completes as illegal.
module idli_xu_m #(
    parameter  int unsigned DATA_W  = 16,
    parameter  int unsigned SLICE_W = 4,
    localparam int unsigned CTR_W   = $clog2(DATA_W / SLICE_W)
) (
    input  logic               i_xu_gck,
    input  logic               i_xu_rst,
    input  logic [CTR_W-1:0]   i_xu_ctr,
    input  logic               i_xu_vld,
    input  logic [2:0]         i_xu_op,
    input  logic               i_xu_stall,
    input  logic [SLICE_W-1:0] i_xu_lhs,
    input  logic [SLICE_W-1:0] i_xu_rhs,
    output logic [SLICE_W-1:0] o_xu_res,
    output logic               o_xu_wr_en,
    output logic               o_xu_busy,
    output logic               o_xu_cout,
    output logic               o_xu_flag,
    output logic               o_xu_illegal
);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_EQ  = 3'd5,
        OP_LTU = 3'd6,
        OP_SHL = 3'd7
    } op_e;

    op_e  r_op;
    logic r_busy;
    logic r_carry;
    logic r_eq;
    logic r_cout;
    logic r_flag;

    logic               w_first;
    logic               w_last;
    logic               w_accept;
    logic               w_inv;
    logic               w_c;
    logic [SLICE_W-1:0] w_b;
    logic [SLICE_W:0]   w_sum;
    logic               w_eq;
    logic [SLICE_W-1:0] w_res;
    logic               w_carry_nxt;
    logic               w_wr;
    logic               w_illegal;

    assign w_first  = (i_xu_ctr == {CTR_W{1'b0}});
    assign w_last   = (i_xu_ctr == {CTR_W{1'b1}});
    assign w_accept = w_last & i_xu_vld & ~i_xu_stall;

    // Subtract-style ops add the inverted RHS with an injected carry on slice 0.
    assign w_inv = (r_op == OP_SUB) || (r_op == OP_LTU);
    assign w_c   = w_first ? w_inv : r_carry;
    assign w_b   = w_inv ? ~i_xu_rhs : i_xu_rhs;
    assign w_sum = {1'b0, i_xu_lhs} + {1'b0, w_b} + {{SLICE_W{1'b0}}, w_c};
    assign w_eq  = (w_first ? 1'b1 : r_eq) & (i_xu_lhs == i_xu_rhs);

    // Per-slice ALU: result slice, next carry, write qualifier, illegal flag.
    always_comb begin
        w_res       = '0;
        w_carry_nxt = r_carry;
        w_wr        = 1'b0;
        w_illegal   = 1'b0;
        case (r_op)
            OP_ADD, OP_SUB: begin
                w_res       = w_sum[SLICE_W-1:0];
                w_carry_nxt = w_sum[SLICE_W];
                w_wr        = 1'b1;
            end
            OP_LTU: begin
                w_carry_nxt = w_sum[SLICE_W];
            end
            OP_AND: begin
                w_res = i_xu_lhs & i_xu_rhs;
                w_wr  = 1'b1;
            end
            OP_OR: begin
                w_res = i_xu_lhs | i_xu_rhs;
                w_wr  = 1'b1;
            end
            OP_XOR: begin
                w_res = i_xu_lhs ^ i_xu_rhs;
                w_wr  = 1'b1;
            end
            OP_EQ: begin
                w_res = '0;
            end
            OP_SHL: begin
`ifdef IDLI_XU_SHIFT_EN
                w_res       = {i_xu_lhs[SLICE_W-2:0], w_c};
                w_carry_nxt = i_xu_lhs[SLICE_W-1];
                w_wr        = 1'b1;
`else
                w_illegal   = 1'b1;
`endif
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Acceptance at the period boundary, per-slice chaining, completion flags.
    always_ff @(posedge i_xu_gck) begin
        if (i_xu_rst) begin
            r_op    <= OP_ADD;
            r_busy  <= 1'b0;
            r_carry <= 1'b0;
            r_eq    <= 1'b0;
            r_cout  <= 1'b0;
            r_flag  <= 1'b0;
        end else begin
            if (r_busy) begin
                r_carry <= w_carry_nxt;
                r_eq    <= w_eq;
                if (w_last) begin
                    case (r_op)
                        OP_ADD, OP_SUB: r_cout <= w_carry_nxt;
`ifdef IDLI_XU_SHIFT_EN
                        OP_SHL:         r_cout <= w_carry_nxt;
`endif
                        OP_EQ:          r_flag <= w_eq;
                        OP_LTU:         r_flag <= ~w_carry_nxt;
                        default:        ;
                    endcase
                end
            end
            if (w_last) begin
                r_busy <= w_accept;
                if (w_accept) begin
                    r_op <= op_e'(i_xu_op);
                end
            end
        end
    end

    assign o_xu_res     = r_busy ? w_res : {SLICE_W{1'b0}};
    assign o_xu_wr_en   = r_busy & w_wr;
    assign o_xu_busy    = r_busy;
    assign o_xu_cout    = r_cout;
    assign o_xu_flag    = r_flag;
    assign o_xu_illegal = r_busy & w_last & w_illegal;

endmodule

// File: tb/tb_idli_xu_m.sv
// Self-checking bench for idli_xu_m: word-level reference model, per-cycle
// compare process, directed scenarios plus randomized instruction stream.
module tb_idli_xu_m;

    localparam int unsigned DW = 16;
    localparam int unsigned SW = 4;
    localparam int unsigned N  = DW / SW;
    localparam int unsigned CW = $clog2(N);

`ifdef IDLI_XU_SHIFT_EN
    localparam bit SHIFT = 1'b1;
`else
    localparam bit SHIFT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] ctr;
    logic          vld;
    logic [2:0]    op;
    logic          stall;
    logic [SW-1:0] lhs;
    logic [SW-1:0] rhs;
    logic [SW-1:0] res;
    logic          wr_en;
    logic          busy;
    logic          cout;
    logic          flag;
    logic          illegal;

    idli_xu_m #(.DATA_W(DW), .SLICE_W(SW)) dut (
        .i_xu_gck    (clk),
        .i_xu_rst    (rst),
        .i_xu_ctr    (ctr),
        .i_xu_vld    (vld),
        .i_xu_op     (op),
        .i_xu_stall  (stall),
        .i_xu_lhs    (lhs),
        .i_xu_rhs    (rhs),
        .o_xu_res    (res),
        .o_xu_wr_en  (wr_en),
        .o_xu_busy   (busy),
        .o_xu_cout   (cout),
        .o_xu_flag   (flag),
        .o_xu_illegal(illegal)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: the instruction currently executing and the visible flags.
    logic          cur_busy = 1'b0;
    logic [2:0]    cur_op   = 3'd0;
    logic [DW-1:0] cur_a    = '0;
    logic [DW-1:0] cur_b    = '0;
    logic [DW-1:0] cur_res  = '0;
    logic          cur_c    = 1'b0;

    // Expectations for the cycle in flight, read by the compare process.
    logic          chk_en  = 1'b0;
    logic          m_busy  = 1'b0;
    logic          m_wr    = 1'b0;
    logic [SW-1:0] m_res   = '0;
    logic          m_ill   = 1'b0;
    logic          m_cout  = 1'b0;
    logic          m_flag  = 1'b0;

    logic [DW-1:0] cap     = '0;
    int            ill_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        else
            n_pass++;
    endtask

    // Whole-word semantics of each opcode.
    function automatic void calc(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 output logic [DW-1:0] r, output logic c);
        logic [DW:0] s;
        r = '0;
        c = 1'b0;
        case (o)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[DW-1:0]; c = s[DW]; end
            3'd1: begin r = a - b; c = (a >= b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd7: begin r = a << 1; c = a[DW-1]; end
            default: ;
        endcase
    endfunction

    function automatic logic writes(input logic [2:0] o);
        return (o <= 3'd4) || (o == 3'd7 && SHIFT);
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy));
            chk("wr_en", 32'(wr_en), 32'(m_wr));
            if (!m_busy || m_wr) chk("res", 32'(res), 32'(m_res));
            chk("cout", 32'(cout), 32'(m_cout));
            chk("flag", 32'(flag), 32'(m_flag));
            chk("illegal", 32'(illegal), 32'(m_ill));
            if (wr_en) cap = {res, cap[DW-1:SW]};
            if (illegal) ill_cnt++;
        end
    end

    // One clock: drive, publish expectations, advance the model past the edge.
    task automatic step(input logic v, input logic [2:0] o, input logic s,
                        input logic [DW-1:0] na, input logic [DW-1:0] nb, input logic r);
        logic [CW-1:0] k;
        logic [DW-1:0] sh;
        logic [DW-1:0] nr;
        logic          nc;
        k      = ctr;
        sh     = cur_res >> (int'(k) * SW);
        m_busy = cur_busy;
        m_wr   = cur_busy && writes(cur_op);
        m_res  = cur_busy ? sh[SW-1:0] : '0;
        m_ill  = cur_busy && cur_op == 3'd7 && !SHIFT && k == CW'(N - 1);
        sh     = cur_a >> (int'(k) * SW);
        lhs    = cur_busy ? sh[SW-1:0] : SW'($urandom);
        sh     = cur_b >> (int'(k) * SW);
        rhs    = cur_busy ? sh[SW-1:0] : SW'($urandom);
        vld    = v;
        op     = o;
        stall  = s;
        rst    = r;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        if (r) begin
            cur_busy = 1'b0;
            m_cout   = 1'b0;
            m_flag   = 1'b0;
        end else if (k == CW'(N - 1)) begin
            if (cur_busy) begin
                case (cur_op)
                    3'd0, 3'd1: m_cout = cur_c;
                    3'd5:       m_flag = (cur_a == cur_b);
                    3'd6:       m_flag = (cur_a < cur_b);
                    3'd7:       if (SHIFT) m_cout = cur_c;
                    default:    ;
                endcase
            end
            cur_busy = v && !s;
            if (cur_busy) begin
                cur_op = o;
                cur_a  = na;
                cur_b  = nb;
                calc(o, na, nb, nr, nc);
                cur_res = nr;
                cur_c   = nc;
            end
        end
        ctr = ctr + 1'b1;
    endtask

    // Run junk cycles up to the next boundary, then present an instruction there.
    task automatic issue(input logic v, input logic [2:0] o, input logic s,
                         input logic [DW-1:0] a, input logic [DW-1:0] b, input int rst_pct);
        while (ctr != CW'(N - 1))
            step(1'($urandom), 3'($urandom), 1'($urandom), DW'($urandom), DW'($urandom),
                 $urandom_range(0, 99) < rst_pct);
        step(v, o, s, a, b, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] wr;
        logic          wc;
        int            ill0;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;

        rst = 1'b1; ctr = '0; vld = 1'b0; op = '0; stall = 1'b0; lhs = '0; rhs = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res", 32'(res), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_flag", 32'(flag), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);

        // ADD 0x00FF + 0x0001
        calc(3'd0, 16'h00FF, 16'h0001, wr, wc);
        chk("model_add", 32'({wc, wr}), 32'h0_0100);
        issue(1'b1, 3'd0, 1'b0, 16'h00FF, 16'h0001, 0);
        issue(1'b0, 3'd0, 1'b0, '0, '0, 0);
        chk("add_word", 32'(cap), 32'h0100);
        chk("add_cout", 32'(cout), 32'd0);

        // SUB 0 - 1 then ADD 0xFFFF + 1 back-to-back
        calc(3'd1, 16'h0000, 16'h0001, wr, wc);
        chk("model_sub", 32'({wc, wr}), 32'h0_FFFF);
        issue(1'b1, 3'd1, 1'b0, 16'h0000, 16'h0001, 0);
        issue(1'b1, 3'd0, 1'b0, 16'hFFFF, 16'h0001, 0);
        chk("sub_word", 32'(cap), 32'hFFFF);
        chk("sub_cout", 32'(cout), 32'd0);
        issue(1'b0, 3'd0, 1'b0, '0, '0, 0);
        chk("add2_word", 32'(cap), 32'h0000);
        chk("add2_cout", 32'(cout), 32'd1);

        // EQ equal, EQ unequal, LTU 3 < 5
        issue(1'b1, 3'd5, 1'b0, 16'h1234, 16'h1234, 0);
        issue(1'b1, 3'd5, 1'b0, 16'h1234, 16'h1235, 0);
        chk("eq1_flag", 32'(flag), 32'd1);
        issue(1'b1, 3'd6, 1'b0, 16'h0003, 16'h0005, 0);
        chk("eq2_flag", 32'(flag), 32'd0);
        issue(1'b0, 3'd0, 1'b0, '0, '0, 0);
        chk("ltu_flag", 32'(flag), 32'd1);

        // Stalled ADD 0 + 0 must not run nor clear cout
        issue(1'b1, 3'd0, 1'b1, 16'h0000, 16'h0000, 0);
        chk("stall_busy", 32'(busy), 32'd0);
        issue(1'b0, 3'd0, 1'b0, '0, '0, 0);
        chk("stall_cout", 32'(cout), 32'd1);
        chk("stall_flag", 32'(flag), 32'd1);

        // Clear cout, then SHL 0x8001
        issue(1'b1, 3'd0, 1'b0, 16'h0000, 16'h0000, 0);
        issue(1'b1, 3'd7, 1'b0, 16'h8001, 16'h0000, 0);
        chk("pre_shl_cout", 32'(cout), 32'd0);
        ill0 = ill_cnt;
        issue(1'b0, 3'd0, 1'b0, '0, '0, 0);
        if (SHIFT) begin
            chk("shl_word", 32'(cap), 32'h0002);
            chk("shl_cout", 32'(cout), 32'd1);
        end else begin
            chk("shl_ill_pulses", 32'(ill_cnt - ill0), 32'd1);
            chk("shl_cout", 32'(cout), 32'd0);
        end

        // Reset during slice 2 of ADD 0xFFFF + 1
        issue(1'b1, 3'd0, 1'b0, 16'hFFFF, 16'h0001, 0);
        step(1'b0, 3'd0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 3'd0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 3'd0, 1'b0, '0, '0, 1'b1);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_wr_en", 32'(wr_en), 32'd0);
        chk("rstmid_res", 32'(res), 32'd0);
        chk("rstmid_cout", 32'(cout), 32'd0);
        chk("rstmid_flag", 32'(flag), 32'd0);
        issue(1'b0, 3'd0, 1'b0, '0, '0, 0);
        chk("rstmid_cout_after", 32'(cout), 32'd0);

        // Randomized instruction stream
        for (int i = 0; i < 400; i++) begin
            ra = DW'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : DW'($urandom);
            if ($urandom_range(0, 4) == 0) rb = ra + DW'($urandom_range(0, 2)) - DW'(1);
            issue($urandom_range(0, 3) != 0, 3'($urandom), $urandom_range(0, 4) == 0, ra, rb, 1);
        end
        issue(1'b0, 3'd0, 1'b0, '0, '0, 0);
        issue(1'b0, 3'd0, 1'b0, '0, '0, 0);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/idli_xu_m.md
# idli_xu_m

Parametrised bit-serial execution unit: the next generation of the idli execution stage, generalised over datapath width and slice width, with a real serial ALU, carry chaining, compare flags and stall-aware instruction acceptance. It sits after decode and the register file. It accepts one instruction per serial period, consumes operand slices LSB-first, produces result slices with a write enable for the register file, and latches carry and compare flags at the end of each instruction.

## Interface
Parameters:
- DATA_W, 16, architectural data width in bits.
- SLICE_W, 4, bits processed per cycle; DATA_W/SLICE_W (N) must be a power of two, at least 2.
- CTR_W, $clog2(DATA_W/SLICE_W), derived localparam, width of the slice counter.

Ports:
- i_xu_gck  in  1  clock; one clock, all state on rising edge.
- i_xu_rst  in  1  reset, synchronous, active-high.
- i_xu_ctr  in  CTR_W  free-running slice counter; all-ones marks the last slice of a period.
- i_xu_vld  in  1  incoming instruction valid; sampled only when i_xu_ctr is all-ones.
- i_xu_op  in  3  opcode, sampled with i_xu_vld.
- i_xu_stall  in  1  sampled with i_xu_vld; high means the instruction is refused.
- i_xu_lhs  in  SLICE_W  LHS operand slice for the current counter value.
- i_xu_rhs  in  SLICE_W  RHS operand slice for the current counter value.
- o_xu_res  out  SLICE_W  result slice, combinational.
- o_xu_wr_en  out  1  register-file write enable for o_xu_res.
- o_xu_busy  out  1  an instruction is executing this cycle.
- o_xu_cout  out  1  carry of the last completed ADD/SUB/SHL.
- o_xu_flag  out  1  result of the last completed EQ/LTU.
- o_xu_illegal  out  1  one-cycle pulse when an unsupported opcode completes.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 EQ, 6 LTU, 7 SHL.
- Acceptance: on a cycle with i_xu_ctr all-ones, i_xu_vld=1 and i_xu_stall=0, the unit registers the opcode and sets busy. Otherwise busy clears at the period boundary.
- State: op_q, busy_q, carry_q, eq_q, cout_q, flag_q.
- Slice k executes on the cycle with i_xu_ctr = k while busy.
  - ADD computes lhs + rhs + c.
  - SUB and LTU compute lhs + ~rhs + c.
  - c is 1 for SUB/LTU and 0 otherwise on slice 0; on later slices c = carry_q.
  - carry_q captures the SLICE_W-bit carry-out every slice.
- AND, OR and XOR are bitwise per slice.
- EQ: eq_q is forced to 1 at slice 0, then ANDed with (lhs == rhs) for each slice.
- SHL (macro present): res = {lhs[SLICE_W-2:0], c}, where c is 0 on slice 0 and carry_q after; carry_q takes lhs[SLICE_W-1].
- Writes: o_xu_wr_en = busy && op in {ADD, SUB, AND, OR, XOR, SHL-if-enabled}. EQ, LTU and illegal ops never write.
- Completion at slice N-1:
  - ADD/SUB/SHL update cout_q with the final carry.
  - EQ sets flag_q to the final eq_q.
  - LTU sets flag_q to the inverse of the final carry, i.e. borrow.
  - Other ops leave cout_q and flag_q unchanged.
- o_xu_res is 0 whenever busy is low.
- Reset:
  - All state clears.
  - Every output resets to 0: res, wr_en, busy, cout, flag, illegal.
  - Reset mid-instruction aborts it: no further wr_en, and no flag or cout update.

## Timing
- Accept on cycle T (ctr all-ones). Execute on T+1..T+N, with wr_en high on those N cycles for writing ops.
- cout and flag are visible from T+N+1.
- An illegal pulse occurs on T+N.
- Back-to-back: a new instruction accepted at T+N executes on T+N+1 with no gap. Flag and carry state restart at its slice 0, independent of the previous instruction.
- Stall high at the boundary: busy drops on T+1. Nothing executes for that period. The refused instruction must be re-presented.
- i_xu_vld, i_xu_op and i_xu_stall are ignored when the counter is not all-ones.

## Configuration
- IDLI_XU_SHIFT_EN defined: SHL (op 7) is implemented as above.
- Macro absent: op 7 is accepted but treated as illegal. It produces no wr_en, does not change cout or flag, and pulses o_xu_illegal at slice N-1.

## Test plan
- ADD 0x00FF + 0x0001 (defaults) -> res slices 0,0,1,0 (0x0100), wr_en 4 cycles, cout 0.
- SUB 0x0000 - 0x0001 -> 0xFFFF written, cout 0. Then ADD 0xFFFF + 0x0001 back-to-back -> 0x0000, cout 1, no idle cycle between them.
- EQ 0x1234 vs 0x1234 -> flag 1. Then EQ 0x1234 vs 0x1235 -> flag 0. Then LTU 3 vs 5 -> flag 1. wr_en never asserted.
- vld=1 with stall=1 on an ADD -> busy and wr_en stay 0 for the whole period; cout and flag unchanged.
- SHL 0x8001: with IDLI_XU_SHIFT_EN -> 0x0002 written, cout 1. Without it -> no write, illegal pulse on the 4th slice.
- Reset asserted at slice 2 of an ADD -> all outputs 0 next cycle; no write on slice 3; cout unchanged at its reset value 0.
